// File: rtl/ov7670_pkg.sv
// rtl/ov7670_pkg.sv - shared constants for the OV7670 capture path
//
// Purpose: default frame geometry, counter widths and frame-sequencer
//          state encodings shared by the capture-path modules.
// Ports:   none (package).
package ov7670_pkg;

  localparam int H_PIX_DEF   = 640;
  localparam int V_LINES_DEF = 480;
  localparam int CNT_W_DEF   = 10;
  localparam int FCNT_W_DEF  = 8;

  // Frame sequencer state enumeration (IDLE, SYNC, CAPT, EOF, HOLD, NEXT)
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_SYNC = 3'd1;
  localparam logic [2:0] ST_CAPT = 3'd2;
  localparam logic [2:0] ST_EOF  = 3'd3;
  localparam logic [2:0] ST_HOLD = 3'd4;
  localparam logic [2:0] ST_NEXT = 3'd5;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop level synchronizer
//
// Purpose: brings an asynchronous level into the pclk domain.
// Ports:   pclk  in  destination clock
//          rst   in  synchronous active-high reset (both flops to RST_VAL)
//          i_d   in  asynchronous level
//          o_q   out synchronized level, two pclk edges of latency
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic pclk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge pclk) begin
    if (rst) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/ov7670_frame_ctrl.sv
// rtl/ov7670_frame_ctrl.sv - OV7670 frame sequencer with ping-pong bank control
//
// Purpose: decides which frames reach the dual-bank pixel buffer (single or
//          continuous), swaps banks only on complete well-formed frames and
//          flags line/frame geometry errors.
// Ports:   pclk, rst           clock, synchronous active-high reset
//          i_vsync, i_href     camera sync signals
//          i_pix_wr            pixel write strobe from the capture datapath
//          i_cmd_start/stop    1-cycle command pulses; i_mode_cont sampled on start
//          i_rd_lock           async reader-busy level (synchronized inside)
//          o_mem_we            gated buffer write (combinational)
//          o_wr_bank/o_rd_bank writer / reader bank select
//          o_busy, o_frame_done, o_err_line, o_err_frame, o_frame_cnt  status
module ov7670_frame_ctrl
  import ov7670_pkg::*;
#(
  parameter int H_PIX   = H_PIX_DEF,
  parameter int V_LINES = V_LINES_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int FCNT_W  = FCNT_W_DEF
) (
  input  logic              pclk,
  input  logic              rst,
  input  logic              i_vsync,
  input  logic              i_href,
  input  logic              i_pix_wr,
  input  logic              i_cmd_start,
  input  logic              i_cmd_stop,
  input  logic              i_mode_cont,
  input  logic              i_rd_lock,
  output logic              o_mem_we,
  output logic              o_wr_bank,
  output logic              o_rd_bank,
  output logic              o_busy,
  output logic              o_frame_done,
  output logic              o_err_line,
  output logic              o_err_frame,
  output logic [FCNT_W-1:0] o_frame_cnt
);

  localparam logic [CNT_W-1:0] LP_H = CNT_W'(H_PIX);
  localparam logic [CNT_W-1:0] LP_V = CNT_W'(V_LINES);

  logic [2:0]        r_state;
  logic [2:0]        w_state_nxt;
  logic              r_vs_d, r_hr_d;
  logic [1:0]        r_chk;
  logic [CNT_W-1:0]  r_pix_cnt, r_line_cnt;
  logic              r_mode_cont, r_stop_pend;
  logic              r_wr_bank, r_rd_bank, r_busy, r_frame_done;
  logic              r_err_line, r_err_frame;
  logic [FCNT_W-1:0] r_frame_cnt;

  logic w_vs_rise, w_vs_fall, w_hr_fall;
  logic w_rd_lock_s, w_cap_en, w_start;
  logic w_eof_ready, w_frame_bad, w_swap;

  sync_2ff #(.RST_VAL(1'b0)) u_rd_lock_sync (
    .pclk (pclk),
    .rst  (rst),
    .i_d  (i_rd_lock),
    .o_q  (w_rd_lock_s)
  );

  assign w_vs_rise = i_vsync & ~r_vs_d;
  assign w_vs_fall = ~i_vsync & r_vs_d;
  assign w_hr_fall = ~i_href & r_hr_d;

  // Capture enable drops combinationally on vs_rise so no pixel of the
  // next frame's blanking ever lands in the bank about to be handed over.
  assign w_cap_en = (r_state == ST_CAPT) & ~w_vs_rise;
  assign o_mem_we = i_pix_wr & w_cap_en;

  assign w_start     = i_cmd_start & ~i_cmd_stop;
  assign w_eof_ready = (r_state == ST_EOF) && (r_chk == 2'b00);
  assign w_frame_bad = (r_line_cnt != LP_V);
  assign w_swap      = (w_eof_ready && !w_frame_bad && !w_rd_lock_s) ||
                       ((r_state == ST_HOLD) && !w_rd_lock_s);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_start) w_state_nxt = ST_SYNC;
      ST_SYNC: begin
        if (i_cmd_stop)     w_state_nxt = ST_IDLE;
        else if (w_vs_fall) w_state_nxt = ST_CAPT;
      end
      ST_CAPT: if (w_vs_rise) w_state_nxt = ST_EOF;
      ST_EOF: begin
        if (w_eof_ready) begin
          if (w_frame_bad || !w_rd_lock_s) w_state_nxt = ST_NEXT;
          else                             w_state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: if (!w_rd_lock_s) w_state_nxt = ST_NEXT;
      ST_NEXT: begin
        if (!r_mode_cont || r_stop_pend || i_cmd_stop) w_state_nxt = ST_IDLE;
        else                                           w_state_nxt = ST_SYNC;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_vs_d       <= 1'b0;
      r_hr_d       <= 1'b0;
      r_chk        <= 2'b00;
      r_pix_cnt    <= '0;
      r_line_cnt   <= '0;
      r_mode_cont  <= 1'b0;
      r_stop_pend  <= 1'b0;
      r_wr_bank    <= 1'b0;
      r_rd_bank    <= 1'b1;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_err_line   <= 1'b0;
      r_err_frame  <= 1'b0;
      r_frame_cnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != ST_IDLE);
      r_vs_d  <= i_vsync;
      r_hr_d  <= i_href;

      // Two-cycle delay after href falls lets the trailing pix_wr land
      // in the count before the line is judged.
      r_chk <= {r_chk[0], (r_state == ST_CAPT) && w_hr_fall};

      if ((r_state == ST_SYNC) && w_vs_fall) begin
        r_pix_cnt  <= '0;
        r_line_cnt <= '0;
      end else if (r_chk[1]) begin
        if (r_pix_cnt != LP_H) r_err_line <= 1'b1;
        r_pix_cnt <= o_mem_we ? CNT_W'(1) : '0;
        if (r_line_cnt != '1) r_line_cnt <= r_line_cnt + 1'b1;
      end else if (o_mem_we && (r_pix_cnt != '1)) begin
        r_pix_cnt <= r_pix_cnt + 1'b1;
      end

      if (w_eof_ready && w_frame_bad) r_err_frame <= 1'b1;

      if (i_cmd_stop && ((r_state == ST_CAPT) || (r_state == ST_EOF) ||
                         (r_state == ST_HOLD)))
        r_stop_pend <= 1'b1;

      // Start clears the sticky errors last so it always wins.
      if ((r_state == ST_IDLE) && w_start) begin
        r_mode_cont <= i_mode_cont;
        r_stop_pend <= 1'b0;
        r_err_line  <= 1'b0;
        r_err_frame <= 1'b0;
      end

      r_frame_done <= w_swap;
      if (w_swap) begin
        r_wr_bank   <= ~r_wr_bank;
        r_rd_bank   <= ~r_rd_bank;
        r_frame_cnt <= r_frame_cnt + 1'b1;
      end
    end
  end

  assign o_wr_bank    = r_wr_bank;
  assign o_rd_bank    = r_rd_bank;
  assign o_busy       = r_busy;
  assign o_frame_done = r_frame_done;
  assign o_err_line   = r_err_line;
  assign o_err_frame  = r_err_frame;
  assign o_frame_cnt  = r_frame_cnt;

endmodule
